tcp_rx_ack_tracker: RTL
=======================

// Module: tcp_rx_ack_tracker
// PURPOSE
//  Per-flow receive-side ACK tracker; sits between the RX header parser and TX/retransmit engines.
//  Holds their_ack_num, their_win_size and dup_ack_cnt per flow.
//  Classifies each incoming ACK and emits an ACK/window update toward TX.
//  Raises a fast-retransmit request at the DUP_THRESH-th duplicate ACK.
// PARAMETERS
//  NUM_FLOWS   MAX_FLOW_CNT (16)     number of tracked flows; FLOWID_W = $clog2(NUM_FLOWS)
//  DUP_THRESH  RT_ACK_THRESHOLD (3)  duplicate ACKs that trigger a retransmit request
//  STAT_W      32                    width of statistics counters (TCP_ACK_STATS_EN only)
// PORTS
//  clk               in   1               clock
//  rst               in   1               asynchronous reset, active-high
//  init_val          in   1               load flow state (connection establish); no ready, always taken
//  init_flowid       in   FLOWID_W        flow to load
//  init_ack_num      in   ACK_NUM_W       initial their_ack_num
//  init_win          in   WIN_SIZE_W      initial their_win_size
//  ack_in_val        in   1               parsed ACK segment valid
//  ack_in_rdy        out  1               tracker accepts ACK this cycle
//  ack_in_flowid     in   FLOWID_W        flow of segment
//  ack_in_ack_num    in   ACK_NUM_W       segment ACK number
//  ack_in_win        in   WIN_SIZE_W      segment window
//  ack_in_pld_len    in   PAYLOAD_ENTRY_LEN_W  segment payload bytes
//  upd_val           out  1               ACK/window update valid
//  upd_rdy           in   1               TX consumes update
//  upd_flowid        out  FLOWID_W
//  upd_ack_num       out  ACK_NUM_W       new their_ack_num
//  upd_win           out  WIN_SIZE_W      new their_win_size
//  rt_val            out  1               fast-retransmit request valid
//  rt_rdy            in   1               retransmit engine consumes request
//  rt_flowid         out  FLOWID_W
//  rt_seq            out  SEQ_NUM_W       sequence number to resend (= duplicated ACK number)
// BEHAVIOUR
//  - Reset: ack_in_rdy=0 during rst; all *_val=0, all output data=0, flow state and stats=0.
//  - ack_in_rdy = ~init_val & (~upd_val | upd_rdy) & (~rt_val | rt_rdy), registered-free (comb).
//  - Accept when ack_in_val & ack_in_rdy. Read flow state combinationally from the flop array,
//    classify, write back at the same clock edge. Outputs registered: latency = 1 cycle.
//  - Back-to-back ACKs to the same flow see the updated state (write occurs before next read).
//  - diff = signed(ack_in_ack_num - stored_ack), 32-bit modular (handles sequence wrap):
//    NEW   diff>0: stored_ack<=ack, win<=ack_in_win, dup<=0; pulse upd.
//    DUP   diff==0, pld_len==0, win==stored_win: dup<=sat_inc(dup) (saturates at 2^DUP_ACK_CNT_W-1);
//          if the new dup == DUP_THRESH exactly, pulse rt with rt_seq=ack. No upd.
//    WIN   diff==0, otherwise: win<=ack_in_win, dup unchanged; pulse upd.
//    STALE diff<0: no state change, no output.
//  - upd_val/rt_val hold with stable data until their rdy is seen; clear on rdy if no new pulse.
//  - init_val overrides: writes state (dup=0), blocks ACK accept that cycle; no output generated.
//  - Reset mid-operation: pending upd/rt requests are dropped; flow state returns to 0.
// CONFIGURATION
//  TCP_ACK_STATS_EN defined: adds outputs stat_dup_cnt, stat_rt_cnt, stat_stale_cnt [STAT_W-1:0].
//    Each increments once per accepted ACK of that class / rt pulse; wraps at 2^STAT_W.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  tcp_pkg additions: typedef ack_in_struct {flowid, ack_num, win, pld_len};
//    enum ack_class_e {ACK_NEW, ACK_DUP, ACK_WIN, ACK_STALE}; reuse ack_state_struct for per-flow dup state.
//  Sub-module tcp_ack_state_rf: NUM_FLOWS-entry flop array, 1 async read and 1 write port, async reset to 0.
//    Init takes the write port over ACK writes.
// TESTING
//  1. init flow 2 ack=1000 win=500; ACK 1460 win 500 -> upd {2,1460,500} next cycle; dup=0.
//  2. Three ACK 1460, len 0, win 500 on flow 2 -> rt {2,1460} exactly once, on the 3rd.
//     A 4th duplicate gives no rt.
//  3. init ack=32'hFFFF_FF00; ACK 32'h0000_0100 -> NEW (wrap), upd 32'h100.
//     Then ACK 32'hFFFF_FF80 -> STALE, no output.
//  4. upd_rdy=0 with upd pending -> ack_in_rdy=0, upd data stable.
//     Release -> next ACK accepted the same cycle.
//  5. init_val and ack_in_val on flow 5 together -> ACK stalled one cycle.
//     Then classified against init values.
//  6. Assert rst with rt_val=1 -> rt_val=0 immediately; after reset all flows read ack=0.

Source files
------------

// File: rtl/tcp_rx_ack_tracker_pkg.sv
// Shared types and constants for the per-flow receive-side ACK tracker.
// Optional statistics counters are enabled with the TCP_ACK_STATS_EN macro.
package tcp_rx_ack_tracker_pkg;

    localparam int NUM_FLOWS           = 16;
    localparam int FLOWID_W            = $clog2(NUM_FLOWS);
    localparam int DUP_THRESH          = 3;
    localparam int STAT_W              = 32;
    localparam int ACK_NUM_W           = 32;
    localparam int SEQ_NUM_W           = 32;
    localparam int WIN_SIZE_W          = 16;
    localparam int PAYLOAD_ENTRY_LEN_W = 16;
    // Wide enough that the counter saturates well above the threshold, so a
    // saturated count can never re-match DUP_THRESH and re-fire a retransmit.
    localparam int DUP_ACK_CNT_W       = 4;

    typedef struct packed {
        logic [FLOWID_W-1:0]            flowid;
        logic [ACK_NUM_W-1:0]           ack_num;
        logic [WIN_SIZE_W-1:0]          win;
        logic [PAYLOAD_ENTRY_LEN_W-1:0] pld_len;
    } ack_in_struct;

    typedef enum logic [1:0] {
        ACK_NEW,
        ACK_DUP,
        ACK_WIN,
        ACK_STALE
    } ack_class_e;

    typedef struct packed {
        logic [ACK_NUM_W-1:0]     ack_num;
        logic [WIN_SIZE_W-1:0]    win;
        logic [DUP_ACK_CNT_W-1:0] dup_cnt;
    } ack_state_struct;

    function automatic logic [DUP_ACK_CNT_W-1:0] sat_inc(input logic [DUP_ACK_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tcp_rx_ack_tracker_state_rf.sv
// Per-flow ACK state storage: flop array, one async read port, one write port.
module tcp_rx_ack_tracker_state_rf
    import tcp_rx_ack_tracker_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [FLOWID_W-1:0] i_rd_flowid,
    output ack_state_struct     o_rd_data,
    input  logic                i_wr_en,
    input  logic [FLOWID_W-1:0] i_wr_flowid,
    input  ack_state_struct     i_wr_data
);

    ack_state_struct r_mem [NUM_FLOWS];

    // Write one entry per cycle; reset clears every flow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_flowid] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_flowid];

endmodule

// File: rtl/tcp_rx_ack_tracker.sv
// Per-flow receive-side ACK tracker: classifies ACKs, emits window/ACK
// updates to TX and fast-retransmit requests on the threshold duplicate.
// Define TCP_ACK_STATS_EN to add dup/rt/stale statistics counters.
module tcp_rx_ack_tracker
    import tcp_rx_ack_tracker_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_init_val,
    input  logic [FLOWID_W-1:0]            i_init_flowid,
    input  logic [ACK_NUM_W-1:0]           i_init_ack_num,
    input  logic [WIN_SIZE_W-1:0]          i_init_win,
    input  logic                           i_ack_in_val,
    output logic                           o_ack_in_rdy,
    input  logic [FLOWID_W-1:0]            i_ack_in_flowid,
    input  logic [ACK_NUM_W-1:0]           i_ack_in_ack_num,
    input  logic [WIN_SIZE_W-1:0]          i_ack_in_win,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0] i_ack_in_pld_len,
    output logic                           o_upd_val,
    input  logic                           i_upd_rdy,
    output logic [FLOWID_W-1:0]            o_upd_flowid,
    output logic [ACK_NUM_W-1:0]           o_upd_ack_num,
    output logic [WIN_SIZE_W-1:0]          o_upd_win,
    output logic                           o_rt_val,
    input  logic                           i_rt_rdy,
    output logic [FLOWID_W-1:0]            o_rt_flowid,
    output logic [SEQ_NUM_W-1:0]           o_rt_seq
`ifdef TCP_ACK_STATS_EN
    ,
    output logic [STAT_W-1:0]              o_stat_dup_cnt,
    output logic [STAT_W-1:0]              o_stat_rt_cnt,
    output logic [STAT_W-1:0]              o_stat_stale_cnt
`endif
);

    ack_in_struct                w_ack_in;
    ack_state_struct             w_rd;
    ack_state_struct             w_wr_data;
    ack_class_e                  w_class;
    logic signed [ACK_NUM_W-1:0] w_diff;
    logic [DUP_ACK_CNT_W-1:0]    w_dup_next;
    logic                        w_accept;
    logic                        w_wr_en;
    logic                        w_upd_fire;
    logic                        w_rt_fire;

    assign w_ack_in = '{flowid:  i_ack_in_flowid,
                        ack_num: i_ack_in_ack_num,
                        win:     i_ack_in_win,
                        pld_len: i_ack_in_pld_len};

    assign o_ack_in_rdy = ~i_rst & ~i_init_val
                        & (~o_upd_val | i_upd_rdy)
                        & (~o_rt_val  | i_rt_rdy);
    assign w_accept     = i_ack_in_val & o_ack_in_rdy;

    // Modular difference so ACK numbers that wrap past 2^32 still count as newer.
    assign w_diff     = signed'(w_ack_in.ack_num - w_rd.ack_num);
    assign w_dup_next = sat_inc(w_rd.dup_cnt);

    // Classify the incoming ACK against the stored flow state.
    always_comb begin
        w_class = ACK_STALE;
        if (w_diff > 0)
            w_class = ACK_NEW;
        else if (w_diff == 0)
            w_class = (w_ack_in.pld_len == '0 && w_ack_in.win == w_rd.win) ? ACK_DUP : ACK_WIN;
    end

    assign w_upd_fire = w_accept & (w_class == ACK_NEW || w_class == ACK_WIN);
    assign w_rt_fire  = w_accept & (w_class == ACK_DUP)
                      & (w_dup_next == DUP_ACK_CNT_W'(DUP_THRESH));

    // Build the write-back entry; init owns the write port when present.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = w_rd;
        if (i_init_val) begin
            w_wr_en   = 1'b1;
            w_wr_data = '{ack_num: i_init_ack_num, win: i_init_win, dup_cnt: '0};
        end else if (w_accept) begin
            unique case (w_class)
                ACK_NEW: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = '{ack_num: w_ack_in.ack_num, win: w_ack_in.win, dup_cnt: '0};
                end
                ACK_DUP: begin
                    w_wr_en           = 1'b1;
                    w_wr_data.dup_cnt = w_dup_next;
                end
                ACK_WIN: begin
                    w_wr_en       = 1'b1;
                    w_wr_data.win = w_ack_in.win;
                end
                default: w_wr_en = 1'b0;
            endcase
        end
    end

    tcp_rx_ack_tracker_state_rf u_state_rf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_flowid (w_ack_in.flowid),
        .o_rd_data   (w_rd),
        .i_wr_en     (w_wr_en),
        .i_wr_flowid (i_init_val ? i_init_flowid : w_ack_in.flowid),
        .i_wr_data   (w_wr_data)
    );

    // Registered update and retransmit outputs; each holds until its rdy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_upd_val     <= 1'b0;
            o_upd_flowid  <= '0;
            o_upd_ack_num <= '0;
            o_upd_win     <= '0;
            o_rt_val      <= 1'b0;
            o_rt_flowid   <= '0;
            o_rt_seq      <= '0;
        end else begin
            if (w_upd_fire) begin
                o_upd_val     <= 1'b1;
                o_upd_flowid  <= w_ack_in.flowid;
                o_upd_ack_num <= w_ack_in.ack_num;
                o_upd_win     <= w_ack_in.win;
            end else if (i_upd_rdy) begin
                o_upd_val <= 1'b0;
            end
            if (w_rt_fire) begin
                o_rt_val    <= 1'b1;
                o_rt_flowid <= w_ack_in.flowid;
                o_rt_seq    <= SEQ_NUM_W'(w_ack_in.ack_num);
            end else if (i_rt_rdy) begin
                o_rt_val <= 1'b0;
            end
        end
    end

`ifdef TCP_ACK_STATS_EN
    // Free-running per-class statistics, wrapping naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stat_dup_cnt   <= '0;
            o_stat_rt_cnt    <= '0;
            o_stat_stale_cnt <= '0;
        end else begin
            if (w_accept && w_class == ACK_DUP)   o_stat_dup_cnt   <= o_stat_dup_cnt + 1'b1;
            if (w_rt_fire)                        o_stat_rt_cnt    <= o_stat_rt_cnt + 1'b1;
            if (w_accept && w_class == ACK_STALE) o_stat_stale_cnt <= o_stat_stale_cnt + 1'b1;
        end
    end
`endif

endmodule
